dmem_dump_ctrl: RTL

Debug-side controller for the MIPS data memory port. It shares the single data-memory port between the CPU MEM stage and a UART dump sequencer. On request while the CPU is halted, it walks every memory word and streams each one as four bytes to the UART transmitter. It sits between the pipeline's MEM stage, the data memory and the debug unit's UART TX.

---
 rtl/dmem_dump_ctrl_pkg.sv | 22 ++
 rtl/dump_byte_serializer.sv | 62 ++++++
 rtl/dmem_dump_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/dmem_dump_ctrl_pkg.sv
// Shared definitions for the data-memory dump controller: FSM state codes
// and word/byte sizing helpers.
package dmem_dump_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_READ  = 3'd1;
   localparam state_t S_LATCH = 3'd2;
   localparam state_t S_SEND  = 3'd3;
   localparam state_t S_WAIT  = 3'd4;
   localparam state_t S_DONE  = 3'd5;

   localparam int LEN_DATA_DFLT  = 32;
   localparam int BYTES_PER_WORD = LEN_DATA_DFLT / 8;

   // Counter width that stays legal when only one value is needed.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// Holds one memory word and streams it MSB byte first as registered
// tx_start/tx_data pulses, one byte per send request.
module dump_byte_serializer
   import dmem_dump_ctrl_pkg::*;
#(
   parameter int N_BYTES = BYTES_PER_WORD
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic                 next_i,
   input  logic                 send_i,
   input  logic [8*N_BYTES-1:0] data_i,
   output logic                 last_o,
   output logic                 tx_start_o,
   output logic [7:0]           tx_data_o
);

   localparam int W      = 8 * N_BYTES;
   localparam int BCNT_W = cnt_width(N_BYTES);

   logic [W-1:0]      word_q, word_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic              tx_start_q;
   logic [7:0]        tx_data_q, tx_data_d;

   assign last_o     = (bcnt_q == BCNT_W'(N_BYTES - 1));
   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      word_d = word_q;
      bcnt_d = bcnt_q;
      if (load_i) begin
         word_d = data_i;
         bcnt_d = '0;
      end else if (next_i) begin
         word_d = word_q << 8;
         if (!last_o) bcnt_d = bcnt_q + BCNT_W'(1);
      end
      // The byte is taken from the word as it will be after this edge, so it
      // lines up with the cycle the FSM spends in SEND.
      tx_data_d = send_i ? word_d[W-1 -: 8] : 8'h00;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q     <= '0;
         bcnt_q     <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         word_q     <= word_d;
         bcnt_q     <= bcnt_d;
         tx_start_q <= send_i;
         tx_data_q  <= tx_data_d;
      end
   end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Shares the data-memory port between the CPU MEM stage and a UART dump
// sequencer that streams every memory word as bytes while the CPU is halted.
module dmem_dump_ctrl
   import dmem_dump_ctrl_pkg::*;
#(
   parameter int LEN_DATA  = LEN_DATA_DFLT,
   parameter int RAM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [LEN_DATA-1:0] cpu_wdata,
   input  logic                cpu_wr,
   input  logic                cpu_rd,
   output logic [LEN_DATA-1:0] cpu_rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [LEN_DATA-1:0] mem_wdata,
   output logic                mem_wr,
   output logic                mem_rd,
   input  logic [LEN_DATA-1:0] mem_rdata,
   input  logic                cpu_halted,
   input  logic                dump_start,
   output logic [7:0]          tx_data,
   output logic                tx_start,
   input  logic                tx_done,
   output logic                dump_busy,
   output logic                dump_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(RAM_DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              dump_busy_q, dump_done_q;
   logic              ser_load, ser_next, ser_last;

   assign cpu_rdata = mem_rdata;
   assign dump_busy = dump_busy_q;
   assign dump_done = dump_done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         dump_busy_q <= 1'b0;
         dump_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dump_busy_q <= (state_d != S_IDLE);
         dump_done_q <= (state_d == S_DONE);
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ser_load = 1'b0;
      ser_next = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dump_start && cpu_halted) begin
               idx_d   = '0;
               state_d = S_READ;
            end
         end
         S_READ:  state_d = S_LATCH;
         S_LATCH: begin
            ser_load = 1'b1;
            state_d  = S_SEND;
         end
         S_SEND:  state_d = S_WAIT;
         S_WAIT: begin
            if (tx_done) begin
               ser_next = 1'b1;
               // Terminal test precedes the increment so idx never wraps.
               if (!ser_last)             state_d = S_SEND;
               else if (idx_q == LAST_IDX) state_d = S_DONE;
               else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_READ;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      if (state_q == S_IDLE) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_wr    = cpu_wr;
         mem_rd    = cpu_rd;
      end else begin
         mem_addr  = idx_q;
         mem_wdata = '0;
         mem_wr    = 1'b0;
         mem_rd    = (state_q == S_READ);
      end
   end

   dump_byte_serializer #(
      .N_BYTES (LEN_DATA / 8)
   ) u_serializer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ser_load),
      .next_i     (ser_next),
      .send_i     (state_d == S_SEND),
      .data_i     (mem_rdata),
      .last_o     (ser_last),
      .tx_start_o (tx_start),
      .tx_data_o  (tx_data)
   );

endmodule
